// File: rtl/psx_controller.sv
// psx_controller
//   PlayStation pad emulator: answers a console poll on the PSX pad port
//   with a button/stick frame that is snapshotted when attention asserts.
//
//   Build option: define PSX_CONTROLLER_ANALOG_EN for the analog pad
//   (ID 0x73, 9-byte frame carrying the stick bytes). Left undefined,
//   the block is a digital pad (ID 0x41, 5-byte frame, stick_state unused).
//
//   Parameters (both must be >= 1)
//     ACK_DELAY    clk cycles from a byte's 8th psx_clk rise to the ack pulse
//     ACK_WIDTH    clk cycles psx_ack is held low
//   Ports
//     clk, rst_n   system clock, asynchronous active-low reset
//     psx_att      console attention (active low), asynchronous
//     psx_clk      console serial clock (idles high), asynchronous
//     psx_cmd      console command bit, LSB first, asynchronous
//     button_state active-low button word
//     stick_state  {RX, RY, LX, LY}
//     psx_data     reply bit, LSB first, 1 = released
//     psx_ack      active-low acknowledge pulse
//     poll_strobe  one-cycle pulse when a complete valid poll frame ends

module psx_controller #(
    parameter int unsigned ACK_DELAY = 100,
    parameter int unsigned ACK_WIDTH = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psx_att,
    input  logic        psx_clk,
    input  logic        psx_cmd,
    input  logic [15:0] button_state,
    input  logic [31:0] stick_state,
    output logic        psx_data,
    output logic        psx_ack,
    output logic        poll_strobe
);

`ifdef PSX_CONTROLLER_ANALOG_EN
    localparam logic [7:0] PAD_ID    = 8'h73;
    localparam logic [3:0] LAST_BYTE = 4'd8;
`else
    localparam logic [7:0] PAD_ID    = 8'h41;
    localparam logic [3:0] LAST_BYTE = 4'd4;
`endif

    localparam int unsigned CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(ACK_DELAY - 1);
    localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(ACK_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK, IGNORE} state_t;

    // ---------------------------------------------------------------
    // Pad-port synchronizers and edge detection
    // ---------------------------------------------------------------
    logic att_meta, att_sync, att_prev;
    logic clk_meta, clk_sync, clk_prev;
    logic cmd_meta, cmd_sync;

    // The attention chain resets low so that releasing reset while a frame
    // is still in progress never looks like a fresh falling edge; the block
    // then waits for attention to go high and fall again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att_meta <= 1'b0;
            att_sync <= 1'b0;
            att_prev <= 1'b0;
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            cmd_meta <= 1'b1;
            cmd_sync <= 1'b1;
        end else begin
            att_meta <= psx_att;
            att_sync <= att_meta;
            att_prev <= att_sync;
            clk_meta <= psx_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            cmd_meta <= psx_cmd;
            cmd_sync <= cmd_meta;
        end
    end

    logic att_fall, att_rise, sclk_fall, sclk_rise;
    assign att_fall  =  att_prev & ~att_sync;
    assign att_rise  = ~att_prev &  att_sync;
    assign sclk_fall =  clk_prev & ~clk_sync;
    assign sclk_rise = ~clk_prev &  clk_sync;

    // ---------------------------------------------------------------
    // Input snapshot, taken as the frame starts
    // ---------------------------------------------------------------
    logic [15:0] snap_buttons;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        snap_buttons <= 16'hFFFF;
        else if (att_fall) snap_buttons <= button_state;
    end

`ifdef PSX_CONTROLLER_ANALOG_EN
    logic [31:0] snap_sticks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        snap_sticks <= 32'h8080_8080;
        else if (att_fall) snap_sticks <= stick_state;
    end
`else
    logic unused_stick;
    assign unused_stick = ^stick_state;
`endif

    // ---------------------------------------------------------------
    // Frame state
    // ---------------------------------------------------------------
    state_t           state, state_n;
    logic [3:0]       byte_idx, idx_n;
    logic [2:0]       bit_ptr, ptr_n;
    logic [2:0]       rise_cnt, rcnt_n;
    logic [6:0]       cmd_sr, cmd_n;
    logic [7:0]       reply, reply_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             frame_done, done_n;
    logic             data_n, ack_n, strobe_n;

    // Reply byte for the byte slot following the current one
    logic [3:0] load_idx;
    logic [7:0] load_byte;

    assign load_idx = byte_idx + 4'd1;

    always_comb begin
        load_byte = 8'hFF;
        case (load_idx)
            4'd1:    load_byte = PAD_ID;
            4'd2:    load_byte = 8'h5A;
            4'd3:    load_byte = snap_buttons[7:0];
            4'd4:    load_byte = snap_buttons[15:8];
`ifdef PSX_CONTROLLER_ANALOG_EN
            4'd5:    load_byte = snap_sticks[31:24];
            4'd6:    load_byte = snap_sticks[23:16];
            4'd7:    load_byte = snap_sticks[15:8];
            4'd8:    load_byte = snap_sticks[7:0];
`endif
            default: load_byte = 8'hFF;
        endcase
    end

    // Command byte as it stands once the current rising edge is shifted in
    logic [7:0] cmd_byte;
    logic       cmd_ok;

    assign cmd_byte = {cmd_sync, cmd_sr};
    assign cmd_ok   = (byte_idx == 4'd0) ? (cmd_byte == 8'h01) :
                      (byte_idx == 4'd1) ? (cmd_byte == 8'h42) : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_idx    <= '0;
            bit_ptr     <= '0;
            rise_cnt    <= '0;
            cmd_sr      <= '0;
            reply       <= '1;
            cnt         <= '0;
            frame_done  <= 1'b0;
            psx_data    <= 1'b1;
            psx_ack     <= 1'b1;
            poll_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            byte_idx    <= idx_n;
            bit_ptr     <= ptr_n;
            rise_cnt    <= rcnt_n;
            cmd_sr      <= cmd_n;
            reply       <= reply_n;
            cnt         <= cnt_n;
            frame_done  <= done_n;
            psx_data    <= data_n;
            psx_ack     <= ack_n;
            poll_strobe <= strobe_n;
        end
    end

    // Completion of the last byte parks the FSM in IDLE with frame_done set;
    // that flag is what turns the closing attention edge into a poll_strobe.
    always_comb begin
        state_n  = state;
        idx_n    = byte_idx;
        ptr_n    = bit_ptr;
        rcnt_n   = rise_cnt;
        cmd_n    = cmd_sr;
        reply_n  = reply;
        cnt_n    = cnt;
        done_n   = frame_done;
        data_n   = psx_data;
        strobe_n = 1'b0;

        if (att_rise) begin
            state_n  = IDLE;
            data_n   = 1'b1;
            strobe_n = frame_done;
            done_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (att_fall) begin
                        state_n = SHIFT;
                        idx_n   = '0;
                        ptr_n   = '0;
                        rcnt_n  = '0;
                        reply_n = 8'hFF;
                        done_n  = 1'b0;
                        data_n  = 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        data_n = reply[bit_ptr];
                        ptr_n  = bit_ptr + 3'd1;
                    end
                    if (sclk_rise) begin
                        cmd_n  = cmd_byte[7:1];
                        rcnt_n = rise_cnt + 3'd1;
                        if (rise_cnt == 3'd7) begin
                            if (!cmd_ok) begin
                                state_n = IGNORE;
                                data_n  = 1'b1;
                            end else if (byte_idx == LAST_BYTE) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                                data_n  = 1'b1;
                            end else begin
                                state_n = ACK_WAIT;
                                idx_n   = load_idx;
                                reply_n = load_byte;
                                ptr_n   = '0;
                                cnt_n   = '0;
                            end
                        end
                    end
                end
                ACK_WAIT: begin
                    if (cnt == DELAY_LAST) begin
                        state_n = ACK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (cnt == WIDTH_LAST) state_n = SHIFT;
                    else                   cnt_n   = cnt + 1'b1;
                end
                IGNORE: begin
                    data_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    data_n  = 1'b1;
                end
            endcase
        end

        ack_n = (state_n != ACK);
    end

endmodule
